// File: rtl/diff_freq_serial_out.sv
// Serial frame transmitter with selectable 10 kHz / 20 kHz bit rate and idle-level policy.
// Define MSB_FIRST_EN to send bit DATA_BIT-1 first; default build sends bit 0 first.
module diff_freq_serial_out #(
   parameter int DATA_BIT    = 8,
   parameter int TICK_10K_HZ = 1000,
   parameter int TICK_20K_HZ = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_sel_freq,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic [1:0]          i_idle_mode,
   input  logic [DATA_BIT-1:0] i_data,
   output logic                o_data,
   output logic                o_done_tick
);

   localparam int TICK_MAX = (TICK_10K_HZ > TICK_20K_HZ) ? TICK_10K_HZ : TICK_20K_HZ;
   localparam int CW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int BW       = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

   localparam logic [1:0] IDLE_LOW    = 2'b00;
   localparam logic [1:0] IDLE_HIGH   = 2'b01;
   localparam logic [1:0] IDLE_KEEP   = 2'b10;
   localparam logic [1:0] IDLE_REPEAT = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t                state_r;
   logic [DATA_BIT-1:0]   data_r;
   logic                  sel_r;
   logic [1:0]            mode_r;
   logic [CW-1:0]         tick_cnt_r;
   logic [BW-1:0]         bit_idx_r;

   logic [CW-1:0]         tick_lim_s;
   logic                  last_tick_s;
   logic                  last_bit_s;
   logic [BW-1:0]         next_idx_s;
   logic                  next_bit_s;
   logic                  first_bit_s;
   logic                  idle_level_s;

   // idx counts transmission order; map it onto the payload bit actually sent
   function automatic logic bit_at(input logic [DATA_BIT-1:0] word, input logic [BW-1:0] idx);
`ifdef MSB_FIRST_EN
      bit_at = word[BW'(DATA_BIT - 1) - idx];
`else
      bit_at = word[idx];
`endif
   endfunction

   // Bit-period limit, end-of-bit/end-of-frame detection and next output values
   always_comb begin
      tick_lim_s   = sel_r ? CW'(TICK_20K_HZ - 1) : CW'(TICK_10K_HZ - 1);
      last_tick_s  = (tick_cnt_r == tick_lim_s);
      last_bit_s   = (bit_idx_r == BW'(DATA_BIT - 1));
      if (last_bit_s) begin
         next_idx_s = {BW{1'b0}};
      end else begin
         next_idx_s = bit_idx_r + BW'(1);
      end
      next_bit_s   = bit_at(data_r, next_idx_s);
      first_bit_s  = bit_at(data_r, {BW{1'b0}});
      case (mode_r)
         IDLE_LOW:  idle_level_s = 1'b0;
         IDLE_HIGH: idle_level_s = 1'b1;
         IDLE_KEEP: idle_level_s = bit_at(data_r, BW'(DATA_BIT - 1));
         default:   idle_level_s = 1'b0;
      endcase
   end

   // Transmit FSM with registered serial data and done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         data_r      <= {DATA_BIT{1'b0}};
         sel_r       <= 1'b0;
         mode_r      <= 2'b00;
         tick_cnt_r  <= {CW{1'b0}};
         bit_idx_r   <= {BW{1'b0}};
         o_data      <= 1'b0;
         o_done_tick <= 1'b0;
      end else if (i_stop) begin
         state_r     <= ST_IDLE;
         tick_cnt_r  <= {CW{1'b0}};
         bit_idx_r   <= {BW{1'b0}};
         o_data      <= 1'b0;
         o_done_tick <= 1'b0;
      end else begin
         o_done_tick <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (i_start) begin
                  state_r    <= ST_SEND;
                  data_r     <= i_data;
                  sel_r      <= i_sel_freq;
                  mode_r     <= i_idle_mode;
                  tick_cnt_r <= {CW{1'b0}};
                  bit_idx_r  <= {BW{1'b0}};
                  o_data     <= bit_at(i_data, {BW{1'b0}});
               end else begin
                  o_data     <= o_data;
               end
            end
            ST_SEND: begin
               if (!last_tick_s) begin
                  tick_cnt_r <= tick_cnt_r + CW'(1);
               end else begin
                  tick_cnt_r <= {CW{1'b0}};
                  bit_idx_r  <= next_idx_s;
                  if (!last_bit_s) begin
                     o_data <= next_bit_s;
                  end else begin
                     o_done_tick <= 1'b1;
                     // REPEAT restarts the same word on the very edge that ends it
                     if (mode_r == IDLE_REPEAT) begin
                        o_data <= first_bit_s;
                     end else begin
                        state_r <= ST_IDLE;
                        o_data  <= idle_level_s;
                     end
                  end
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               tick_cnt_r <= {CW{1'b0}};
               bit_idx_r  <= {BW{1'b0}};
               o_data     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diff_freq_serial_out.sv
// Self-checking bench for diff_freq_serial_out: elapsed-time reference model plus pinned literal frames.
module tb_diff_freq_serial_out;

   localparam int DATA_BIT = 8;
   localparam int T10      = 1000;
   localparam int T20      = 500;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_sel_freq = 1'b0;
   logic       i_start = 1'b0;
   logic       i_stop = 1'b0;
   logic [1:0] i_idle_mode = 2'b00;
   logic [7:0] i_data = 8'h00;
   logic       o_data;
   logic       o_done_tick;

   int checks = 0;
   int errors = 0;

   diff_freq_serial_out #(
      .DATA_BIT   (DATA_BIT),
      .TICK_10K_HZ(T10),
      .TICK_20K_HZ(T20)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sel_freq (i_sel_freq),
      .i_start    (i_start),
      .i_stop     (i_stop),
      .i_idle_mode(i_idle_mode),
      .i_data     (i_data),
      .o_data     (o_data),
      .o_done_tick(o_done_tick)
   );

   always #5 clk = ~clk;

   // k-th transmitted bit of a word
   function automatic logic order_bit(input logic [7:0] w, input int k);
`ifdef MSB_FIRST_EN
      return w[7-k];
`else
      return w[k];
`endif
   endfunction

   function automatic logic idle_of(input logic [1:0] m, input logic [7:0] w);
      case (m)
         2'd0:    return 1'b0;
         2'd1:    return 1'b1;
         default: return order_bit(w, 7);
      endcase
   endfunction

   // Literal sequences below are written with bit j = j-th bit on the wire (LSB-first build)
   function automatic logic [7:0] ord(input logic [7:0] s);
`ifdef MSB_FIRST_EN
      logic [7:0] r;
      for (int j = 0; j < 8; j++) r[j] = s[7-j];
      return r;
`else
      return s;
`endif
   endfunction

`ifdef MSB_FIRST_EN
   localparam logic KEEP_80 = 1'b0;
`else
   localparam logic KEEP_80 = 1'b1;
`endif

   // Reference model: output is a function of cycles elapsed since the frame started
   int         cyc = 0;
   int         m_start = 0;
   int         m_n = T10;
   logic       m_active = 1'b0;
   logic       m_data = 1'b0;
   logic       m_done = 1'b0;
   logic [7:0] m_word = 8'h00;
   logic [1:0] m_mode = 2'b00;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_data   <= 1'b0;
         m_done   <= 1'b0;
      end else if (i_stop) begin
         m_active <= 1'b0;
         m_data   <= 1'b0;
         m_done   <= 1'b0;
      end else if (m_active) begin
         if (cyc - m_start == DATA_BIT * m_n) begin
            m_done <= 1'b1;
            if (m_mode == 2'd3) begin
               m_start <= cyc;
               m_data  <= order_bit(m_word, 0);
            end else begin
               m_active <= 1'b0;
               m_data   <= idle_of(m_mode, m_word);
            end
         end else begin
            m_done <= 1'b0;
            m_data <= order_bit(m_word, (cyc - m_start) / m_n);
         end
      end else begin
         m_done <= 1'b0;
         if (i_start) begin
            m_active <= 1'b1;
            m_start  <= cyc;
            m_word   <= i_data;
            m_n      <= i_sel_freq ? T20 : T10;
            m_mode   <= i_idle_mode;
            m_data   <= order_bit(i_data, 0);
         end
      end
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   // One clock: inputs already set; compare against the model on the falling edge
   task automatic step();
      @(negedge clk);
      check("model_data", o_data, m_data);
      check("model_done", o_done_tick, m_done);
   endtask

   task automatic start_frame(input logic [7:0] w, input logic sel, input logic [1:0] mode);
      i_data      = w;
      i_sel_freq  = sel;
      i_idle_mode = mode;
      i_start     = 1'b1;
      step();
      i_start     = 1'b0;
   endtask

   // Walk edges 1..edges after a start edge, pinning literal bit values and done pulses
   task automatic pin_run(input logic [7:0] seq, input int n, input int edges,
                          input int start_edge, input int stop_edge,
                          input logic idle_after, input logic rep);
      for (int e = 1; e <= edges; e++) begin
         i_start = (e == start_edge);
         i_stop  = (e == stop_edge);
         step();
         i_start = 1'b0;
         i_stop  = 1'b0;
         if (stop_edge > 0 && e >= stop_edge) begin
            if (e == stop_edge || e % 1000 == 0) begin
               check("stop_data", o_data, 1'b0);
               check("stop_done", o_done_tick, 1'b0);
            end
         end else if (e % (8 * n) == 0) begin
            check("done_pulse", o_done_tick, 1'b1);
            check("frame_end_data", o_data, rep ? seq[0] : idle_after);
         end else if (e % (8 * n) == 8 * n - 1) begin
            check("done_early", o_done_tick, 1'b0);
         end else if (e % n == n / 2) begin
            check("bit_value", o_data, seq[(e / n) % 8]);
         end
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_data", o_data, 1'b0);
      check("rst_done", o_done_tick, 1'b0);
      rst_n = 1'b1;
      step();

      // 8'h55 high speed, idle HIGH
      start_frame(8'h55, 1'b1, 2'b01);
      check("first_bit_55", o_data, ord(8'h55) & 8'h01 ? 1'b1 : 1'b0);
      pin_run(ord(8'h55), T20, 8 * T20, 0, 0, 1'b1, 1'b0);

      // next start issued in the done-tick cycle: 8'hAA low speed, idle HIGH
      start_frame(8'hAA, 1'b0, 2'b01);
      check("b2b_done_clear", o_done_tick, 1'b0);
      check("b2b_first_bit", o_data, ord(8'hAA) & 8'h01 ? 1'b1 : 1'b0);
      pin_run(ord(8'hAA), T10, 8 * T10, 0, 0, 1'b1, 1'b0);
      step();
      check("idle_high_after", o_data, 1'b1);

      // 8'hF0 high speed, idle LOW
      start_frame(8'hF0, 1'b1, 2'b00);
      check("first_bit_f0", o_data, 1'b0);
      pin_run(ord(8'hF0), T20, 8 * T20, 0, 0, 1'b0, 1'b0);
      step();
      check("idle_low_after", o_data, 1'b0);

      // 8'h80 high speed, idle KEEP; inputs scrambled and a start poked mid-frame
      start_frame(8'h80, 1'b1, 2'b10);
      i_data      = 8'h00;
      i_sel_freq  = 1'b0;
      i_idle_mode = 2'b00;
      pin_run(ord(8'h80), T20, 8 * T20, 1000, 0, KEEP_80, 1'b0);
      repeat (3) step();
      check("keep_hold", o_data, KEEP_80);

      // 8'h0F high speed, REPEAT, stopped at edge 9000
      start_frame(8'h0F, 1'b1, 2'b11);
      check("first_bit_0f", o_data, ord(8'h0F) & 8'h01 ? 1'b1 : 1'b0);
      pin_run(ord(8'h0F), T20, 14000, 0, 9000, 1'b0, 1'b1);

      // reset mid-frame at edge 2000, then a normal frame
      start_frame(8'hC3, 1'b1, 2'b01);
      repeat (1999) step();
      rst_n = 1'b0;
      step();
      check("midrst_data", o_data, 1'b0);
      check("midrst_done", o_done_tick, 1'b0);
      rst_n = 1'b1;
      step();
      start_frame(8'h3C, 1'b1, 2'b01);
      check("post_rst_first", o_data, ord(8'h3C) & 8'h01 ? 1'b1 : 1'b0);
      pin_run(ord(8'h3C), T20, 8 * T20, 0, 0, 1'b1, 1'b0);

      // randomized episodes: random words/modes, stray starts, stops and one reset
      for (int k = 0; k < 4; k++) begin
         int len;
         int stop_e;
         int rst_e;
         start_frame(8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         len    = $urandom_range(3000, 9000);
         stop_e = $urandom_range(len / 2, len);
         rst_e  = (k == 2) ? $urandom_range(100, len / 2) : 0;
         for (int e = 1; e <= len; e++) begin
            i_start = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) == 0) begin
               i_data      = 8'($urandom);
               i_sel_freq  = 1'($urandom_range(0, 1));
               i_idle_mode = 2'($urandom_range(0, 3));
            end
            i_stop = (e == stop_e);
            rst_n  = (e != rst_e);
            step();
         end
         i_start = 1'b0;
         i_stop  = 1'b0;
         rst_n   = 1'b1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/diff_freq_serial_out.md
DIFF_FREQ_SERIAL_OUT -- requirements
Module: diff_freq_serial_out

Interface
REQ-001 Parameter DATA_BIT, default 8: frame width in bits.
REQ-002 Parameter TICK_10K_HZ, default 1000: clocks per bit in low-speed mode (10 MHz clk / 10 kHz).
REQ-003 Parameter TICK_20K_HZ, default 500: clocks per bit in high-speed mode (10 MHz clk / 20 kHz).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_sel_freq  input  1  0 = low speed (TICK_10K_HZ), 1 = high speed (TICK_20K_HZ).
REQ-007 i_start  input  1  one-clock start request.
REQ-008 i_stop  input  1  abort request, level-sampled each clock.
REQ-009 i_idle_mode  input  2  00 LOW, 01 HIGH, 10 KEEP, 11 REPEAT.
REQ-010 i_data  input  DATA_BIT  frame payload.
REQ-011 o_data  output  1  registered serial data.
REQ-012 o_done_tick  output  1  registered one-clock end-of-frame pulse.

Function
REQ-013 FSM has two states: IDLE and SEND.
REQ-014 In IDLE, i_start=1 sampled at a rising edge latches i_data, i_sel_freq and i_idle_mode, enters SEND, and drives o_data = first bit at that same edge.
REQ-015 Bit period N = TICK_20K_HZ if latched sel_freq=1, else TICK_10K_HZ; each bit held on o_data for exactly N clocks.
REQ-016 Bit order LSB first (bit 0 first) unless REQ-027 applies.
REQ-017 Frame length: DATA_BIT*N clocks from the start-sampling edge to the edge ending the last bit.
REQ-018 At the edge ending the last bit: o_done_tick=1 for exactly one clock; latched mode LOW/HIGH/KEEP returns FSM to IDLE with o_data = 0 / 1 / last transmitted bit respectively.
REQ-019 REPEAT: at the edge ending the last bit, FSM stays in SEND, o_done_tick pulses, o_data = first bit of the latched word again with no gap; repeats indefinitely until i_stop.
REQ-020 i_start accepted in the clock cycle during which o_done_tick is high (FSM already IDLE); back-to-back frames allowed with one idle-level clock between them.
REQ-021 i_start while in SEND ignored; latched data, speed and mode unchanged mid-frame.
REQ-022 i_stop=1 at any edge: FSM to IDLE, o_data=0, bit/clock counters cleared, o_done_tick=0 (no pulse for an aborted frame); i_stop has priority over i_start in the same cycle.
REQ-023 In IDLE, o_data holds the idle level set by the last completed frame (0 after reset or stop).
REQ-024 Bit-period counter width ceil(log2(max(TICK_10K_HZ,TICK_20K_HZ))); bit index counter width ceil(log2(DATA_BIT)); no wrap-around beyond N-1 / DATA_BIT-1.

Reset
REQ-025 rst_n=0 sampled at rising edge: FSM IDLE, o_data=0, o_done_tick=0, counters and latched registers 0; rst_n takes priority over i_stop and i_start.
REQ-026 Reset asserted mid-frame aborts the frame with no o_done_tick.

Configuration
REQ-027 Macro MSB_FIRST_EN: when defined, frames transmit bit DATA_BIT-1 first down to bit 0, and KEEP holds bit 0; when undefined, LSB first per REQ-016, and KEEP holds bit DATA_BIT-1.

Verification
REQ-028 Start 8'h55, high speed, IDLE_HIGH -> o_data 1,0,1,0,1,0,1,0 each 500 clk; o_done_tick one clock at 4000 clk; o_data=1 afterward.
REQ-029 Next start issued in done-tick cycle: 8'hAA, low speed, IDLE_HIGH -> 0,1,0,1,0,1,0,1 each 1000 clk; done at 8000 clk; o_data=1.
REQ-030 8'hF0, high speed, IDLE_LOW -> 0,0,0,0,1,1,1,1 each 500 clk; done at 4000; o_data=0 afterward.
REQ-031 8'h80, high speed, IDLE_KEEP -> last bit 1 held after done; i_start pulsed at clk 1000 mid-frame ignored.
REQ-032 8'h0F, high speed, IDLE_REPEAT -> done tick every 4000 clk, pattern repeats with no gap; i_stop at clk 9000 -> o_data=0, FSM IDLE, no further done tick.
REQ-033 rst_n=0 at clk 2000 mid-frame -> next edge o_data=0, o_done_tick=0; new start after reset transmits normally.
